// File: rtl/fft8_pkg.sv
`default_nettype none
// ============================================================================
// fft8_pkg : shared constants, types and helpers for the 8-point FFT/IFFT pair
// Revision : 1.0
// ============================================================================
package fft8_pkg;

  localparam int          N      = 8;
  localparam int          IN_W   = 17;
  localparam int          OUT_W  = 16;
  localparam int          BUF_W  = 18;
  localparam logic [14:0] C_Q14  = 15'h2D41;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_S1     = 3'd1,
    ST_S2     = 3'd2,
    ST_S3     = 3'd3,
    ST_UNLOAD = 3'd4
  } state_t;

  // Twiddle applied to the second butterfly operand (inverse direction).
  typedef enum logic [1:0] {
    TW_ONE   = 2'd0,
    TW_C1PJ  = 2'd1,
    TW_PJ    = 2'd2,
    TW_CM1PJ = 2'd3
  } tw_t;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  function automatic logic signed [OUT_W-1:0] sat16(input logic signed [BUF_W-1:0] v);
    if (v > 18'sd32767)
      return 16'sh7fff;
    else if (v < -18'sd32768)
      return 16'sh8000;
    else
      return v[OUT_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifft8_bfly.sv
`default_nettype none
// ============================================================================
// ifft8_bfly : combinational radix-2 butterfly with inverse twiddle, halved out
// Revision   : 1.0
// ============================================================================
module ifft8_bfly
  import fft8_pkg::*;
(
  input  logic signed [BUF_W-1:0] i_a_re,
  input  logic signed [BUF_W-1:0] i_a_im,
  input  logic signed [BUF_W-1:0] i_b_re,
  input  logic signed [BUF_W-1:0] i_b_im,
  input  tw_t                     i_tw,
  output logic signed [BUF_W-1:0] o_sum_re,
  output logic signed [BUF_W-1:0] o_sum_im,
  output logic signed [BUF_W-1:0] o_dif_re,
  output logic signed [BUF_W-1:0] o_dif_im
);

  localparam logic signed [32:0] c_c33 = 33'(C_Q14);

  logic signed [32:0]      w_rpi;
  logic signed [32:0]      w_rmi;
  logic signed [BUF_W-1:0] w_bt_re;
  logic signed [BUF_W-1:0] w_bt_im;
  logic signed [BUF_W:0]   w_s_re;
  logic signed [BUF_W:0]   w_s_im;
  logic signed [BUF_W:0]   w_d_re;
  logic signed [BUF_W:0]   w_d_im;

  assign w_rpi = 33'(i_b_re) + 33'(i_b_im);
  assign w_rmi = 33'(i_b_re) - 33'(i_b_im);

  // C(1+j) and C(-1+j) fold (r +/- i) before the single scaled multiply.
  always_comb begin
    w_bt_re = i_b_re;
    w_bt_im = i_b_im;
    case (i_tw)
      TW_C1PJ: begin
        w_bt_re = BUF_W'((w_rmi * c_c33) >>> 14);
        w_bt_im = BUF_W'((w_rpi * c_c33) >>> 14);
      end
      TW_PJ: begin
        w_bt_re = -i_b_im;
        w_bt_im = i_b_re;
      end
      TW_CM1PJ: begin
        w_bt_re = BUF_W'(((-w_rpi) * c_c33) >>> 14);
        w_bt_im = BUF_W'((w_rmi * c_c33) >>> 14);
      end
      default: ;
    endcase
  end

  assign w_s_re = (BUF_W+1)'(i_a_re) + (BUF_W+1)'(w_bt_re);
  assign w_s_im = (BUF_W+1)'(i_a_im) + (BUF_W+1)'(w_bt_im);
  assign w_d_re = (BUF_W+1)'(i_a_re) - (BUF_W+1)'(w_bt_re);
  assign w_d_im = (BUF_W+1)'(i_a_im) - (BUF_W+1)'(w_bt_im);

  assign o_sum_re = BUF_W'(w_s_re >>> 1);
  assign o_sum_im = BUF_W'(w_s_im >>> 1);
  assign o_dif_re = BUF_W'(w_d_re >>> 1);
  assign o_dif_im = BUF_W'(w_d_im >>> 1);

endmodule
`default_nettype wire

// File: rtl/ifft8_stream.sv
`default_nettype none
// ============================================================================
// ifft8_stream : streaming 8-point radix-2 DIT inverse FFT, serial in/out
// Revision     : 1.0
// ============================================================================
module ifft8_stream
  import fft8_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_re,
  input  logic signed [IN_W-1:0]  in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im,
  output logic                    out_last
);

  state_t                  r_state;
  state_t                  w_next;
  logic [2:0]              r_k;
  logic [2:0]              r_n;
  logic signed [BUF_W-1:0] r_buf_re [N];
  logic signed [BUF_W-1:0] r_buf_im [N];
  logic signed [OUT_W-1:0] r_out_re;
  logic signed [OUT_W-1:0] r_out_im;
  logic                    r_out_last;

  logic                    w_in_hs;
  logic                    w_out_hs;
  logic [2:0]              w_ia     [N/2];
  logic [2:0]              w_ib     [N/2];
  tw_t                     w_tw     [N/2];
  logic signed [BUF_W-1:0] w_sum_re [N/2];
  logic signed [BUF_W-1:0] w_sum_im [N/2];
  logic signed [BUF_W-1:0] w_dif_re [N/2];
  logic signed [BUF_W-1:0] w_dif_im [N/2];

  assign in_ready  = (r_state == ST_LOAD) && !rst;
  assign out_valid = (r_state == ST_UNLOAD);
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = out_valid && out_ready;
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;
  assign out_last  = r_out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD:   if (w_in_hs && r_k == 3'd7) w_next = ST_S1;
      ST_S1:     w_next = ST_S2;
      ST_S2:     w_next = ST_S3;
      ST_S3:     w_next = ST_UNLOAD;
      ST_UNLOAD: if (w_out_hs && r_n == 3'd7) w_next = ST_LOAD;
      default:   w_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k <= 3'd0;
      r_n <= 3'd0;
    end else begin
      if (w_in_hs)  r_k <= r_k + 3'd1;
      if (w_out_hs) r_n <= r_n + 3'd1;
    end
  end

  // Stage pairings: S1 spans 1, S2 spans 2 (+j on odd lanes), S3 spans 4 (twiddle = lane).
  for (genvar gi = 0; gi < N/2; gi++) begin : g_bfly
    localparam logic [1:0] c_i = 2'(gi);

    assign w_ia[gi] = (r_state == ST_S1) ? {c_i, 1'b0} :
                      (r_state == ST_S2) ? {c_i[1], 1'b0, c_i[0]} : {1'b0, c_i};
    assign w_ib[gi] = (r_state == ST_S1) ? {c_i, 1'b1} :
                      (r_state == ST_S2) ? {c_i[1], 1'b1, c_i[0]} : {1'b1, c_i};
    assign w_tw[gi] = (r_state == ST_S3)               ? tw_t'(c_i) :
                      (r_state == ST_S2 && c_i[0])     ? TW_PJ      : TW_ONE;

    ifft8_bfly u_bfly (
      .i_a_re   (r_buf_re[w_ia[gi]]),
      .i_a_im   (r_buf_im[w_ia[gi]]),
      .i_b_re   (r_buf_re[w_ib[gi]]),
      .i_b_im   (r_buf_im[w_ib[gi]]),
      .i_tw     (w_tw[gi]),
      .o_sum_re (w_sum_re[gi]),
      .o_sum_im (w_sum_im[gi]),
      .o_dif_re (w_dif_re[gi]),
      .o_dif_im (w_dif_im[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_buf_re[bitrev3(r_k)] <= BUF_W'(in_re);
      r_buf_im[bitrev3(r_k)] <= BUF_W'(in_im);
    end else if (r_state == ST_S1 || r_state == ST_S2 || r_state == ST_S3) begin
      for (int i = 0; i < N/2; i++) begin
        r_buf_re[w_ia[i]] <= w_sum_re[i];
        r_buf_im[w_ia[i]] <= w_sum_im[i];
        r_buf_re[w_ib[i]] <= w_dif_re[i];
        r_buf_im[w_ib[i]] <= w_dif_im[i];
      end
    end
  end

  // x[0] is taken straight from the S3 butterfly so it is valid on the first UNLOAD cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_re   <= '0;
      r_out_im   <= '0;
      r_out_last <= 1'b0;
    end else if (r_state == ST_S3) begin
      r_out_re   <= sat16(w_sum_re[0]);
      r_out_im   <= sat16(w_sum_im[0]);
      r_out_last <= 1'b0;
    end else if (w_out_hs) begin
      if (r_n != 3'd7) begin
        r_out_re   <= sat16(r_buf_re[r_n + 3'd1]);
        r_out_im   <= sat16(r_buf_im[r_n + 3'd1]);
        r_out_last <= (r_n == 3'd6);
      end else begin
        r_out_last <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifft8_stream.sv
`default_nettype none
// Scoreboarded bench for ifft8_stream: random and directed frames against a stage-level model.
module tb_ifft8_stream;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [16:0] in_re;
  logic signed [16:0] in_im;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_re;
  logic signed [15:0] out_im;
  logic               out_last;

  ifft8_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  localparam longint C = 11585;

  int n_checks = 0;
  int n_pass   = 0;
  int bins_re [8];
  int bins_im [8];
  int q_re [$];
  int q_im [$];
  bit q_last [$];
  int got_re [8];
  int got_im [8];
  int ref_re [8];
  int ref_im [8];
  int pos = 0;
  int frames_done = 0;
  int nf = 0;
  bit bp = 1'b0;
  bit ready_forced = 1'b0;
  bit chk_rdy_next = 1'b0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Inverse twiddle W8^-e applied to (r + j i), with the fixed-point rules of the block.
  function automatic void tw_mul(input longint r, input longint i, input int e,
                                 output longint tr, output longint ti);
    case (e)
      0:       begin tr = r;                     ti = i;                   end
      1:       begin tr = ((r - i) * C) >>> 14;  ti = ((r + i) * C) >>> 14; end
      2:       begin tr = -i;                    ti = r;                   end
      default: begin tr = ((-(r + i)) * C) >>> 14; ti = ((r - i) * C) >>> 14; end
    endcase
  endfunction

  function automatic int sat(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic void model_push();
    longint re [8];
    longint im [8];
    longint tr, ti, ar, ai;
    logic [2:0] kb;
    for (int k = 0; k < 8; k++) begin
      kb = 3'(k);
      re[{kb[0], kb[1], kb[2]}] = bins_re[k];
      im[{kb[0], kb[1], kb[2]}] = bins_im[k];
    end
    for (int span = 1; span < 8; span = span * 2)
      for (int base = 0; base < 8; base += 2 * span)
        for (int j = 0; j < span; j++) begin
          int p, q;
          p = base + j;
          q = p + span;
          tw_mul(re[q], im[q], j * (4 / span), tr, ti);
          ar = re[p];
          ai = im[p];
          re[p] = (ar + tr) >>> 1;
          im[p] = (ai + ti) >>> 1;
          re[q] = (ar - tr) >>> 1;
          im[q] = (ai - ti) >>> 1;
        end
    for (int n = 0; n < 8; n++) begin
      q_re.push_back(sat(re[n]));
      q_im.push_back(sat(im[n]));
      q_last.push_back(n == 7);
    end
  endfunction

  task automatic fill(input int re0, input int im0, input int re_rest, input int im_rest);
    for (int k = 0; k < 8; k++) begin
      bins_re[k] = (k == 0) ? re0 : re_rest;
      bins_im[k] = (k == 0) ? im0 : im_rest;
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < 8; k++) begin
      bins_re[k] = int'($urandom_range(0, 131071)) - 65536;
      bins_im[k] = int'($urandom_range(0, 131071)) - 65536;
    end
  endtask

  // Called and returns at posedge+1.
  task automatic send_frame(input bit gaps, input int nsend, input bit chk_lat);
    int k = 0;
    int guard = 0;
    bit rdy, v;
    while (k < nsend && guard < 400) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_re    = 17'(bins_re[k]);
      in_im    = 17'(bins_im[k]);
      @(negedge clk);
      rdy = in_ready;
      v   = in_valid;
      @(posedge clk);
      #1;
      if (v && rdy) k++;
      guard++;
    end
    in_valid = 1'b0;
    if (k < nsend) chk("input_accept_timeout", k, nsend);
    if (nsend == 8 && k == 8) begin
      model_push();
      nf++;
    end
    if (chk_lat && k == 8) begin
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        chk($sformatf("out_valid_at_t+%0d", c), out_valid, (c == 4));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frames(input int target);
    int g = 0;
    while (frames_done < target && g < 1000) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    if (frames_done < target) chk("frame_completion_timeout", frames_done, target);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    q_re.delete();
    q_im.delete();
    q_last.delete();
    pos = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Output pacing.
  initial forever begin
    @(posedge clk);
    #1;
    if (!ready_forced) out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    int hr, hi, er, ei;
    bit hl, el;
    bit held = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_rdy_next) begin
        chk_rdy_next = 1'b0;
        if (!rst) begin
          chk("in_ready_after_last_out", in_ready, 1);
          chk("out_valid_after_last_out", out_valid, 0);
        end
      end
      if (rst || !out_valid) begin
        held = 1'b0;
      end else begin
        chk("in_ready_low_while_unloading", in_ready, 0);
        if (held) begin
          chk("stall_hold_re", out_re, hr);
          chk("stall_hold_im", out_im, hi);
          chk("stall_hold_last", out_last, hl);
        end
        if (out_ready) begin
          held = 1'b0;
          if (q_re.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            er = q_re.pop_front();
            ei = q_im.pop_front();
            el = q_last.pop_front();
            chk($sformatf("out_re[n=%0d]", pos), out_re, er);
            chk($sformatf("out_im[n=%0d]", pos), out_im, ei);
            chk($sformatf("out_last[n=%0d]", pos), out_last, el);
            got_re[pos & 7] = out_re;
            got_im[pos & 7] = out_im;
            pos++;
            if (el) begin
              pos = 0;
              frames_done++;
              chk_rdy_next = 1'b1;
            end
          end
        end else begin
          held = 1'b1;
          hr   = out_re;
          hi   = out_im;
          hl   = out_last;
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_out_re", out_re, 0);
    chk("reset_out_im", out_im, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    // All bins equal: energy lands on x[0] only.
    fill(8, 0, 8, 0);
    send_frame(1'b0, 8, 1'b1);
    wait_frames(nf);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("flat_x%0d_re", n), got_re[n], (n == 0) ? 8 : 0);
      chk($sformatf("flat_x%0d_im", n), got_im[n], 0);
    end

    // DC bin.
    fill(800, 0, 0, 0);
    send_frame(1'b0, 8, 1'b0);
    wait_frames(nf);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("dc_x%0d_re", n), got_re[n], 100);
      chk($sformatf("dc_x%0d_im", n), got_im[n], 0);
    end

    // Single tone at bin 1.
    fill(0, 0, 0, 0);
    bins_re[1] = 800;
    send_frame(1'b0, 8, 1'b0);
    wait_frames(nf);
    chk("tone_x1_re_near_70.7", (got_re[1] >= 70 && got_re[1] <= 71), 1);
    chk("tone_x1_im_near_70.7", (got_im[1] >= 70 && got_im[1] <= 71), 1);
    chk("tone_x2_re", got_re[2], 0);
    chk("tone_x2_im", got_im[2], 100);
    chk("tone_x4_re", got_re[4], -100);
    chk("tone_x4_im", got_im[4], 0);

    // Saturation.
    fill(65535, 0, 65535, 0);
    send_frame(1'b0, 8, 1'b0);
    wait_frames(nf);
    chk("sat_x0_re", got_re[0], 32767);

    // Reset after five accepted bins.
    fill_random();
    send_frame(1'b0, 5, 1'b0);
    do_reset();
    fill(800, 0, 0, 0);
    send_frame(1'b0, 8, 1'b0);
    wait_frames(nf);
    for (int n = 0; n < 8; n++) chk($sformatf("post_rst1_x%0d_re", n), got_re[n], 100);

    // Reset while presenting x[3].
    fill(0, 0, 0, 0);
    bins_re[1] = 800;
    send_frame(1'b0, 8, 1'b0);
    nf--;
    begin
      int g = 0;
      while (pos < 3 && g < 100) begin
        @(negedge clk);
        #2;
        g++;
      end
      ready_forced = 1'b1;
      out_ready    = 1'b0;
      chk("reached_unload_n3", pos, 3);
    end
    @(posedge clk);
    #1;
    do_reset();
    ready_forced = 1'b0;
    out_ready    = 1'b1;
    fill(8, 0, 8, 0);
    send_frame(1'b0, 8, 1'b0);
    wait_frames(nf);
    for (int n = 0; n < 8; n++) chk($sformatf("post_rst2_x%0d_re", n), got_re[n], (n == 0) ? 8 : 0);

    // Same random frame without and with backpressure.
    fill_random();
    send_frame(1'b0, 8, 1'b0);
    wait_frames(nf);
    for (int n = 0; n < 8; n++) begin
      ref_re[n] = got_re[n];
      ref_im[n] = got_im[n];
    end
    bp = 1'b1;
    send_frame(1'b0, 8, 1'b0);
    wait_frames(nf);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("bp_vs_nostall_x%0d_re", n), got_re[n], ref_re[n]);
      chk($sformatf("bp_vs_nostall_x%0d_im", n), got_im[n], ref_im[n]);
    end

    // Back-to-back random frames with input gaps and output stalls.
    for (int f = 0; f < 30; f++) begin
      fill_random();
      send_frame(1'b1, 8, 1'b0);
    end
    wait_frames(nf);
    chk("scoreboard_drained", q_re.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifft8_stream.md
# ifft8_stream

Streaming 8-point radix-2 DIT inverse FFT. It is the return path for the parallel 8-point forward FFT: it accepts 17-bit complex frequency bins serially under valid/ready, buffers one frame, and computes x[n] = (1/8)·Σ X[k]·W8^(−nk) in three butterfly cycles. It then streams 16-bit time-domain samples out in natural order under valid/ready. It sits between the spectral-processing stage and the sample sink.

## Interface
- N, 8, frame length; fixed, not overridable.
- IN_W, 17, input component width (signed; matches the forward FFT output).
- OUT_W, 16, output component width (signed).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input bin valid.
- in_ready  out  1  block accepts a bin this cycle.
- in_re, in_im  in  IN_W  bin X[k], with k given by arrival order 0..7.
- out_valid  out  1  output sample valid.
- out_ready  in  1  sink accepts a sample.
- out_re, out_im  out  OUT_W  sample x[n], n = 0..7.
- out_last  out  1  high with x[7].

## Operation
- FSM states: LOAD, S1, S2, S3, UNLOAD. Reset state is LOAD.
- LOAD:
  - in_ready=1, held low while rst is high.
  - Each handshake (in_valid & in_ready) writes the bin to buffer address bitrev3(k) and increments k (3-bit).
  - On the handshake with k=7, go to S1 and clear k.
- S1: for pairs (0,1)(2,3)(4,5)(6,7), a'=(a+b)>>>1 and b'=(a−b)>>>1. Twiddle is 1.
- S2: for pairs (0,2)(1,3)(4,6)(5,7), twiddle on the second operand is 1 for the first of each pair group and +j for the second. +j·(r+ji) = (−i + jr). Then butterfly and >>>1.
- S3: for pairs (0,4)(1,5)(2,6)(3,7), twiddles are W^0=1, W^−1=C(1+j), W^−2=+j, W^−3=C(−1+j). Then butterfly and >>>1.
- UNLOAD:
  - out_valid=1. The output is buffer[n], saturated to OUT_W, with n advancing on each out_valid & out_ready.
  - On the handshake at n=7, return to LOAD and clear n.
- Arithmetic:
  - Buffer entries are 18-bit signed. Inputs are sign-extended.
  - C = 15'h2D41 (11585, Q1.14).
  - Twiddle product is (v·C)>>>14, computed on a 33-bit intermediate. The real and imaginary parts are formed as (r±i) before the multiply.
  - All shifts are arithmetic (floor). There is no rounding.
- Saturation: if value > 32767, output 32767; if value < −32768, output −32768.
- Input is ignored outside LOAD: in_ready=0, and in_valid is not sampled.
- Reset mid-frame:
  - Any partial input frame or pending output frame is discarded.
  - State goes to LOAD with k=n=0. The buffer contents are don't-care.

## Timing
- Reset values: in_ready=0 while rst is high and 1 after release; out_valid=0; out_last=0; out_re=out_im=0.
- Input throughput: 1 bin/cycle in LOAD.
- Latency:
  - The k=7 handshake occurs at cycle t.
  - S1, S2 and S3 occupy t+1, t+2 and t+3.
  - out_valid first rises at t+4 with x[0].
- out_re, out_im and out_last are registered. They hold stable while out_valid & !out_ready.
- The last-output handshake occurs at cycle u. in_ready rises at u+1, and out_valid=0 at u+1. Input and output frames never overlap.
- Minimum frame period is 8+3+8 = 19 cycles, reached with no stalls.

## Structure
- Package fft8_pkg contains:
  - localparams N=8, C_Q14=15'h2D41, IN_W and OUT_W;
  - the state enum typedef;
  - function bitrev3;
  - function sat16 (18-bit to 16-bit saturation).
- The forward FFT shares the same package constants.
- One sub-module, ifft8_bfly, is combinational. It takes:
  - two complex 18-bit operands;
  - a 2-bit twiddle select (1, C(1+j), +j, C(−1+j)).
  - It returns the halved sum and difference.
- Four instances are reused across S1–S3, with operand muxing by state.
- FSM, counters, buffer and output register live in ifft8_stream.

## Test plan
- Impulse response:
  - Stimulus: X[k]=8+0j for all k, out_ready=1.
  - Required: x[0]=8+0j and x[1..7]=0. out_valid rises 4 cycles after the 8th input. out_last is high only on x[7].
- DC:
  - Stimulus: X[0]=800, all other bins 0.
  - Required: all 8 outputs are 100+0j.
- Single tone:
  - Stimulus: X[1]=800.
  - Required: x[n]≈100·e^{j2πn/8} within ±1 LSB. Specifically x[1]≈(70,70), x[2]=(0,100) and x[4]=(−100,0).
- Backpressure:
  - Stimulus: random out_ready, ~50% duty.
  - Required:
    - outputs are identical to the no-stall run;
    - data is stable whenever out_valid & !out_ready;
    - in_ready stays 0 until 1 cycle after the x[7] handshake.
- Reset mid-operation:
  - Stimulus: assert rst after 5 inputs, and separately during UNLOAD at n=3.
  - Required: out_valid=0 and in_ready=0 during reset. The next full frame then produces the correct result with no stale samples.
- Saturation and round-trip:
  - Saturation stimulus: X[k]=65535 for all k. Required: x[0]=32767.
  - Round-trip stimulus: 100 random vectors passed through the forward FFT, then this block. Required: the original 16-bit inputs are recovered within ±3 LSB.
